// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared data-memory types: access size, arbiter state, request record
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        mem_size_t   size;
        logic        sext;
        logic        we;
    } mem_req_t;

endpackage

// File: rtl/dmem_misalign_chk.sv
// rtl/dmem_misalign_chk.sv - combinational alignment check for a data-memory access
//   addr_lo : address bits [1:0]
//   size    : access size
//   err     : 1 when a half access is odd or a word access is not 4-byte aligned
module dmem_misalign_chk
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  mem_size_t  size,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        case (size)
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = |addr_lo;
            default: err = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter/sequencer between the MEM stage and a debug port
//   clock, reset_n                 : clock, asynchronous active-low reset
//   pipe_* / dbg_*                 : requester ports (req held until ready/ack)
//   pipe_ready / dbg_ack           : one-cycle completion pulse per port
//   rsp_rdata, rsp_err             : response of the completing access
//   stall                          : pipe_req & ~pipe_ready
//   mem_addr/wdata/size/sext/we    : memory control, driven only during ACCESS
//   mem_rdata                      : combinational memory read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    input  logic [1:0]  pipe_size,
    input  logic        pipe_sext,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [1:0]  dbg_size,
    output logic        pipe_ready,
    output logic        dbg_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sext,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    arb_state_t state, state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] starve_cnt;
    mem_req_t   req_q;
    logic       owner_dbg;

    mem_req_t   win_req;
    logic       win_err;
    logic       grant_dbg;
    logic       grant_pipe;
    logic       grant_any;
    logic       access_last;

    // Arbitration happens only in IDLE; the pipeline wins unless it is absent
    // or the debug port has been passed over STARVE_LIMIT times in a row.
    assign grant_dbg   = (state == IDLE) && dbg_req &&
                         (!pipe_req || (starve_cnt == 4'(STARVE_LIMIT)));
    assign grant_pipe  = (state == IDLE) && pipe_req && !grant_dbg;
    assign grant_any   = grant_dbg || grant_pipe;
    assign access_last = (state == ACCESS) && (wait_cnt == 4'd0);

    // Debug reads are always zero-extended.
    always_comb begin
        win_req = '{addr: pipe_addr, wdata: pipe_wdata, size: mem_size_t'(pipe_size),
                    sext: pipe_sext, we: pipe_we};
        if (grant_dbg) begin
            win_req = '{addr: dbg_addr, wdata: dbg_wdata, size: mem_size_t'(dbg_size),
                        sext: 1'b0, we: dbg_we};
        end
    end

    dmem_misalign_chk u_misalign (
        .addr_lo (win_req.addr[1:0]),
        .size    (win_req.size),
        .err     (win_err)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = win_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pipe_ready = (state == RESP) && !owner_dbg;
        dbg_ack    = (state == RESP) && owner_dbg;
        mem_we     = access_last && req_q.we;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_size   = 2'd0;
        mem_sext   = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
            mem_size  = req_q.size;
            mem_sext  = req_q.sext;
        end
    end

    assign stall = pipe_req && !pipe_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt   <= 4'd0;
            starve_cnt <= 4'd0;
            req_q      <= '0;
            owner_dbg  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (!dbg_req || grant_dbg) begin
                starve_cnt <= 4'd0;
            end else if (grant_pipe && (starve_cnt != 4'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        req_q     <= win_req;
                        owner_dbg <= grant_dbg;
                        wait_cnt  <= 4'(WAIT_STATES);
                        // A misaligned access completes immediately with its error.
                        if (win_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= req_q.we ? 32'd0 : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
